sign_narrow: RTL and testbench

SIGN_NARROW -- requirements
Module: Sign_Narrow

---
 rtl/sign_narrow.sv | 114 +++++++++++
 tb/tb_sign_narrow.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sign_narrow.sv
// Narrows a 32-bit two's-complement stream to 16 bits behind a valid/ready skid buffer,
// flagging and counting out-of-range words. Define SIGN_NARROW_SATURATE_EN to clamp instead of wrap.
module sign_narrow #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [15:0]      data_o,
  output logic             ovf_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] ovf_cnt_o
);

  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q,  out_data_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             skid_valid_q, skid_valid_d;
  logic [15:0]      skid_data_q,  skid_data_d;
  logic             skid_ovf_q,   skid_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        deliver;
  logic        in_ovf;
  logic [15:0] in_val;

  // The input fits in 16 bits only when the upper 17 bits are a pure sign extension.
  always_comb begin
    in_ovf = !((&data_i[31:15]) || !(|data_i[31:15]));
`ifdef SIGN_NARROW_SATURATE_EN
    if (in_ovf) begin
      in_val = data_i[31] ? 16'h8000 : 16'h7FFF;
    end else begin
      in_val = data_i[15:0];
    end
`else
    in_val = data_i[15:0];
`endif
  end

  assign accept  = valid_i && ready_o;
  assign deliver = out_valid_q && ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ovf_d    = out_ovf_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ovf_d   = skid_ovf_q;

    if (!out_valid_q || deliver) begin
      // Output slot frees up: the skid entry is older than anything arriving now.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_ovf_d    = skid_ovf_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_val;
        out_ovf_d   = in_ovf;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_val;
      skid_ovf_d   = in_ovf;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (deliver && out_ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ovf_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ovf_q   <= skid_ovf_d;
      cnt_q        <= cnt_d;
    end
  end

  // ready_o comes straight from a flop, so it never depends on ready_i in the same cycle.
  assign ready_o   = !skid_valid_q;
  assign valid_o   = out_valid_q;
  assign data_o    = out_data_q;
  assign ovf_o     = out_ovf_q;
  assign ovf_cnt_o = cnt_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Directed self-checking bench for sign_narrow (CNT_W = 2) using immediate assertions.
module tb_sign_narrow;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;
  logic        ovf_o;
  logic        cnt_clr_i;
  logic [1:0]  ovf_cnt_o;

  int checks = 0;
  int errors = 0;

`ifdef SIGN_NARROW_SATURATE_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h2345;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

  sign_narrow #(.CNT_W(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .ovf_o     (ovf_o),
    .cnt_clr_i (cnt_clr_i),
    .ovf_cnt_o (ovf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b1; cnt_clr_i = 1'b0;
    #1 rst_i = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_cnt", 32'(ovf_cnt_o), 32'd0);
    @(posedge clk_i);
    #3 rst_i = 1'b1;

    // In-range extremes, one cycle latency each with ready_i held high
    valid_i = 1'b1; data_i = 32'hFFFF_8000;
    tick();
    chk("min_valid", 32'(valid_o), 32'd1);
    chk("min_data", 32'(data_o), 32'h8000);
    chk("min_ovf", 32'(ovf_o), 32'd0);
    data_i = 32'h0000_7FFF;
    tick();
    chk("max_data", 32'(data_o), 32'h7FFF);
    chk("max_ovf", 32'(ovf_o), 32'd0);
    valid_i = 1'b0;
    tick();
    chk("drain_valid", 32'(valid_o), 32'd0);
    chk("drain_cnt", 32'(ovf_cnt_o), 32'd0);

    // Positive overflow
    valid_i = 1'b1; data_i = 32'h0001_2345;
    tick();
    valid_i = 1'b0;
    chk("povf_data", 32'(data_o), 32'(EXP_POS_OVF));
    chk("povf_ovf", 32'(ovf_o), 32'd1);
    chk("povf_cnt_pre", 32'(ovf_cnt_o), 32'd0);
    tick();
    chk("povf_cnt", 32'(ovf_cnt_o), 32'd1);
    chk("povf_empty", 32'(valid_o), 32'd0);

    // Backpressure fills output and skid, third word refused
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h1;
    tick();
    chk("bp1_ready", 32'(ready_o), 32'd1);
    chk("bp1_data", 32'(data_o), 32'h0001);
    data_i = 32'h2;
    tick();
    chk("bp2_ready", 32'(ready_o), 32'd0);
    chk("bp2_data", 32'(data_o), 32'h0001);
    data_i = 32'h3;
    tick();
    chk("bp3_ready", 32'(ready_o), 32'd0);
    chk("bp3_data", 32'(data_o), 32'h0001);
    chk("bp3_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    tick();
    chk("bp_out2", 32'(data_o), 32'h0002);
    chk("bp_ready_back", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("bp_out3", 32'(data_o), 32'h0003);
    tick();
    chk("bp_drained", 32'(valid_o), 32'd0);

    // Counter saturation and clear priority
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("clr_cnt", 32'(ovf_cnt_o), 32'd0);
    valid_i = 1'b1; data_i = 32'h8000_0000;
    tick();
    chk("novf_data", 32'(data_o), 32'(EXP_NEG_OVF));
    chk("novf_ovf", 32'(ovf_o), 32'd1);
    tick();
    tick();
    chk("sat_cnt2", 32'(ovf_cnt_o), 32'd2);
    tick();
    chk("sat_cnt3", 32'(ovf_cnt_o), 32'd3);
    tick();
    valid_i = 1'b0;
    tick();
    chk("sat_cnt5", 32'(ovf_cnt_o), 32'd3);
    valid_i = 1'b1; data_i = 32'h0001_2345;
    tick();
    valid_i = 1'b0; cnt_clr_i = 1'b1;
    chk("six_ovf", 32'(ovf_o), 32'd1);
    tick();
    cnt_clr_i = 1'b0;
    chk("clr_over_inc", 32'(ovf_cnt_o), 32'd0);
    chk("six_delivered", 32'(valid_o), 32'd0);

    // Reset with both registers full
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h11;
    tick();
    data_i = 32'h22;
    tick();
    valid_i = 1'b0;
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_valid", 32'(valid_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_data", 32'(data_o), 32'd0);
    #2 rst_i = 1'b1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'h55;
    tick();
    valid_i = 1'b0;
    chk("post_first", 32'(data_o), 32'h0055);
    chk("post_valid", 32'(valid_o), 32'd1);
    tick();
    chk("post_nostale", 32'(valid_o), 32'd0);
    tick();
    chk("post_nostale2", 32'(valid_o), 32'd0);

    // Negative in-range word
    valid_i = 1'b1; data_i = 32'hFFFF_FFFF;
    tick();
    valid_i = 1'b0;
    chk("neg1_data", 32'(data_o), 32'hFFFF);
    chk("neg1_ovf", 32'(ovf_o), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
